// File: rtl/prog_loader.sv
// Boot-time image loader: framed byte stream -> byte memory writes.
// Holds the core in reset until the payload checksum is verified.
module prog_loader #(
  parameter logic [31:0] MEM_BYTES = 32'h0025_0000,
  parameter int unsigned RST_HOLD  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ready,
  input  logic        reload,
  output logic        core_rst,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_CSUM,
    S_HOLD,
    S_RUN,
    S_ERR
  } state_e;

  state_e      state_q;
  logic [2:0]  hdr_cnt_q;
  logic [31:0] base_q;
  logic [23:0] len_q;
  logic [31:0] rcv_q;
  logic [31:0] rem_q;
  logic [31:0] hold_q;
  logic [7:0]  acc_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [7:0]  wdata_q;
  logic        core_rst_q;
  logic        done_q;
  logic        err_q;

  logic        take;
  logic        wr_done;
  logic [31:0] n_full;
  logic [32:0] room;
  logic        range_bad;

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign core_rst  = core_rst_q;
  assign done      = done_q;
  assign err       = err_q;

  assign take    = in_valid & in_ready;
  assign wr_done = we_q & mem_ready;

  // Length completes on the 8th header byte; check in 33 bits so no wrap.
  assign n_full    = {in_data, len_q};
  assign room      = {1'b0, MEM_BYTES} - {1'b0, base_q};
  assign range_bad = (base_q >= MEM_BYTES) ||
                     ({1'b0, n_full} > room);

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      S_HDR:   in_ready = 1'b1;
      S_CSUM:  in_ready = 1'b1;
      S_DATA:  in_ready = (rcv_q != '0) &&
                          (!we_q || mem_ready);
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_HDR;
      hdr_cnt_q  <= '0;
      base_q     <= '0;
      len_q      <= '0;
      rcv_q      <= '0;
      rem_q      <= '0;
      hold_q     <= '0;
      acc_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_HDR: begin
          if (take) begin
            hdr_cnt_q <= hdr_cnt_q + 3'd1;
            if (!hdr_cnt_q[2])
              base_q <= {in_data, base_q[31:8]};
            else
              len_q <= {in_data, len_q[23:8]};
            if (hdr_cnt_q == 3'd7) begin
              hdr_cnt_q <= '0;
              if (range_bad) begin
                state_q <= S_ERR;
                err_q   <= 1'b1;
              end else if (n_full == '0) begin
                state_q <= S_CSUM;
              end else begin
                state_q <= S_DATA;
                addr_q  <= base_q;
                rcv_q   <= n_full;
                rem_q   <= n_full;
              end
            end
          end
        end
        S_DATA: begin
          // addr_q always points at the pending or next write slot.
          if (wr_done) begin
            addr_q <= addr_q + 32'd1;
            acc_q  <= acc_q + wdata_q;
            rem_q  <= rem_q - 32'd1;
          end
          if (take) begin
            we_q    <= 1'b1;
            wdata_q <= in_data;
            rcv_q   <= rcv_q - 32'd1;
          end else if (wr_done) begin
            we_q <= 1'b0;
          end
          if (wr_done && rem_q == 32'd1)
            state_q <= S_CSUM;
        end
        S_CSUM: begin
          if (take) begin
            hold_q <= '0;
            if (in_data == acc_q) begin
              state_q <= S_HOLD;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (hold_q == 32'(RST_HOLD - 1)) begin
            state_q    <= S_RUN;
            core_rst_q <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            hold_q <= hold_q + 32'd1;
          end
        end
        S_RUN, S_ERR: begin
          if (reload) begin
            state_q    <= S_HDR;
            hdr_cnt_q  <= '0;
            rcv_q      <= '0;
            rem_q      <= '0;
            hold_q     <= '0;
            acc_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= S_ERR;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader that sits directly upstream of the pipelined RV32I core top and its byte memory.
- Accepts a framed byte stream: header, payload, checksum.
- Writes payload bytes into unified memory and holds the core in reset until the image is verified.
- Replaces testbench-side memory preloading so the same image can be loaded in hardware.

Parameters:
- MEM_BYTES, 32'h00250000, size of byte-addressed memory; the highest legal address is MEM_BYTES-1.
- RST_HOLD, 8, number of cycles core_rst stays high after a good checksum before release (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle; a transfer occurs when in_valid&in_ready.
- mem_we  out  1  byte write strobe to memory.
- mem_addr  out  32  byte address.
- mem_wdata  out  8  byte to write.
- mem_ready  in  1  memory accepts the write this cycle; the write completes when mem_we&mem_ready.
- reload  in  1  single-cycle pulse; restarts loading from S_RUN or S_ERR.
- core_rst  out  1  active-high reset to the core.
- done  out  1  image loaded and verified; core running.
- err  out  1  frame error (range or checksum).

Behaviour:
- Reset values: state=S_HDR, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, core_rst=1, done=0, err=0, byte counters=0, checksum accumulator=0.
- Reset takes priority over everything. Reset mid-load discards the partial image, does not clean up memory, and returns to S_HDR.
- Frame format: 4-byte base address (little-endian), 4-byte length N (little-endian), N payload bytes, then 1 checksum byte equal to the 8-bit sum mod 256 of the payload.
- S_HDR:
  - Accepts 8 bytes and assembles BASE and N.
  - On the 8th byte: if BASE>=MEM_BYTES, or N>MEM_BYTES-BASE (range check done in 33-bit arithmetic, no wrap), go to S_ERR.
  - Else if N==0, go to S_CSUM.
  - Else go to S_DATA with the address counter set to BASE.
- S_DATA:
  - One-entry buffer. A byte accepted with in_ready=1 is registered; mem_we asserts the next cycle with mem_addr=counter and mem_wdata=byte.
  - in_ready=0 while a write is pending and mem_ready=0; in_ready=1 otherwise, i.e. back-to-back at 1 byte/cycle when mem_ready is held high.
  - On each completed write: address counter +1, checksum accumulator += byte (8-bit wrap), remaining count -1.
  - After the N-th write completes, go to S_CSUM. The last write must complete before the transition.
- S_CSUM: accepts 1 byte. If it equals the accumulator, go to S_HOLD; else go to S_ERR.
- S_HOLD: in_ready=0. core_rst stays 1 for exactly RST_HOLD cycles, then go to S_RUN.
- S_RUN: core_rst=0, done=1, in_ready=0. Stream bytes are ignored (not consumed).
- S_ERR: err=1, core_rst=1, done=0, in_ready=0.
- reload in S_RUN or S_ERR: next cycle go to S_HDR; core_rst=1, done=0, err=0, accumulator and counters cleared. reload in any other state is ignored.
- mem_we is never asserted outside S_DATA, and never to an address outside [BASE, BASE+N-1].
- Stream and write happening in the same cycle is legal. A byte accepted in the cycle its predecessor's write completes is handled without loss or duplication.

Test Plan:
- Basic load: stream BASE=0x00000000, N=4, payload 13 00 00 00, csum 0x13, mem_ready=1 → four writes to addresses 0..3 on consecutive cycles; core_rst falls 8 cycles after the checksum byte; done=1.
- Backpressure: same frame with mem_ready low for 3 cycles on the 2nd write → in_ready=0 during the stall; memory 0..3 = 13 00 00 00; exactly 4 mem_we&mem_ready events.
- Bad checksum: BASE=0x100, N=2, payload FF 02, csum 0x00 (correct is 0x01) → err=1, core_rst stays 1, done=0; then reload plus a correct frame → done=1, err=0.
- Range error: BASE=0x0024FFFE, N=4 → err=1 after the 8th header byte, zero mem_we; also BASE=0xFFFFFFFF, N=1 → err=1 (no 32-bit wrap).
- Zero length: BASE=0x5000, N=0, csum 0x00 → no writes; done=1 after RST_HOLD.
- Reset mid-load: assert rst after 2 of 4 payload bytes → next cycle in S_HDR with core_rst=1, mem_we=0; a new full frame loads correctly.
